zap_wb_arbiter: RTL and testbench
=================================

# zap_wb_arbiter

Parametrised N-master Wishbone B3 arbiter for the ZAP memory subsystem. It merges NUM_MASTERS master ports onto one slave port, for example code cache, data cache, DMA and debug. Arbitration is round-robin. A grant is held for the whole burst, so CTI bursts are never split. A watchdog forcibly releases a grant when the slave stops responding. The block sits between the cache/MMU masters and the external bus.

## Interface
Parameters:
- NUM_MASTERS, 4, number of master ports (2..8)
- TIMEOUT, 256, cycles without ack before forced release; 0 disables the watchdog

Ports (master buses are flattened; master k occupies slice k):
- i_clk  in  1  clock
- i_reset  in  1  reset: synchronous, active-high, on i_clk
- i_m_wb_cyc  in  NUM_MASTERS  per-master cycle
- i_m_wb_stb  in  NUM_MASTERS  per-master strobe (request)
- i_m_wb_wen  in  NUM_MASTERS  per-master write enable
- i_m_wb_sel  in  4*NUM_MASTERS  byte selects
- i_m_wb_dat  in  32*NUM_MASTERS  write data
- i_m_wb_adr  in  32*NUM_MASTERS  address
- i_m_wb_cti  in  3*NUM_MASTERS  cycle type
- o_m_wb_ack  out  NUM_MASTERS  per-master ack
- o_wb_cyc, o_wb_stb, o_wb_wen  out  1 each  slave-side controls
- o_wb_sel  out  4  slave-side byte selects
- o_wb_dat  out  32  slave-side write data
- o_wb_adr  out  32  slave-side address
- o_wb_cti  out  3  slave-side cycle type
- i_wb_ack  in  1  slave ack
- o_grant  out  $clog2(NUM_MASTERS)  current owner index; valid while o_busy
- o_busy  out  1  a grant is active
- o_timeout  out  1  one-cycle pulse when the watchdog fires

Read data is returned on a shared bus outside this block.

## Operation
- The FSM has two states, IDLE and BUSY. It holds three registers:
  - owner_ff, the current grant index
  - last_ff, the most recently granted index
  - wdog_ff, the watchdog counter
- **IDLE:**
  - All o_wb_* outputs and o_m_wb_ack are 0.
  - If any i_m_wb_stb[k] is high, the winner is chosen.
  - Round-robin winner: the first requester found scanning from last_ff+1, wrapping modulo NUM_MASTERS.
  - On a winner: owner_ff <= winner, last_ff <= winner, wdog_ff <= 0, go to BUSY.
- **BUSY:**
  - o_wb_* are driven combinationally from master owner_ff's inputs.
  - o_m_wb_ack[owner_ff] = i_wb_ack. All other acks are 0.
  - Non-owner requests are ignored and stalled; they are never dropped.
- **Release from BUSY to IDLE**, whichever occurs first:
  - (a) i_wb_ack while the owner's cti is 3'b000 (classic) or 3'b111 (end-of-burst).
  - (b) The owner's cyc is low (master abort). No ack is issued.
  - (c) TIMEOUT != 0 and wdog_ff == TIMEOUT-1 with no ack in that cycle. The block pulses o_timeout for one cycle and does not generate an ack.
- **Watchdog:** wdog_ff increments each BUSY cycle without ack, clears on every ack, and saturates at TIMEOUT-1.
- **Bursts:** an ack with cti 3'b001 or 3'b010 keeps the grant, so all beats of a burst stay with one master.
- **Simultaneous events:**
  - Ack and watchdog expiry in the same cycle: the ack wins, normal release, no o_timeout.
  - Ack and owner cyc low in the same cycle: the ack is forwarded, then release.
- **Reset:**
  - State IDLE, owner_ff = 0, last_ff = NUM_MASTERS-1 (so master 0 has highest first priority), wdog_ff = 0.
  - All outputs 0.
  - Reset mid-transfer aborts immediately; o_wb_cyc and o_wb_stb are 0 in the cycle after the reset edge.

## Timing
- Grant latency: a request seen in IDLE at edge n makes o_wb_stb valid in cycle n+1.
- Ack path: combinational, zero latency from i_wb_ack to o_m_wb_ack.
- Output path in BUSY: combinational from the owner's inputs, no added latency.
- Turnaround: after every release, one IDLE cycle with o_wb_cyc = 0. This cycle prevents re-granting a master whose stb is still high during its own ack cycle.
- Minimum cost per classic transfer: 1 arbitration cycle plus the slave latency.

## Configuration
- `ZAP_WB_ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority; the lowest requesting index always wins, and last_ff is unused.
  - Undefined (default): round-robin as described above.

## Test plan
- NUM_MASTERS=4; masters 0 and 2 issue classic reads together; slave acks 1 cycle after stb -> master 0 granted first, o_grant=0, idle gap, then o_grant=2. Each master receives exactly one ack.
- All 4 masters request continuously with classic transfers -> grant order 0,1,2,3,0,1. No master is granted twice before all others have been granted.
- Master 1 issues a 4-beat incrementing burst (cti 010,010,010,111) while master 3 requests -> master 1 holds the grant for all 4 acks; master 3 is granted after the IDLE cycle.
- TIMEOUT=8; slave never acks master 2 -> after 8 BUSY cycles o_timeout pulses once, o_wb_cyc drops, o_m_wb_ack[2] stays 0, and the next requester is granted.
- Master 0 drops cyc mid-burst -> release without ack; the next cycle is IDLE with o_wb_stb=0.
- i_reset asserted while BUSY with o_grant=3 -> the next cycle has all outputs 0, o_busy=0, and first post-reset priority goes to master 0.

Source files
------------

// File: rtl/zap_wb_arbiter.sv
// zap_wb_arbiter: N-master Wishbone B3 round-robin arbiter with burst hold and watchdog release.
// Define ZAP_WB_ARB_FIXED_PRIO_EN to select fixed lowest-index priority instead of round-robin.
module zap_wb_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int TIMEOUT     = 256
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic [NUM_MASTERS-1:0]         i_m_wb_cyc,
  input  logic [NUM_MASTERS-1:0]         i_m_wb_stb,
  input  logic [NUM_MASTERS-1:0]         i_m_wb_wen,
  input  logic [4*NUM_MASTERS-1:0]       i_m_wb_sel,
  input  logic [32*NUM_MASTERS-1:0]      i_m_wb_dat,
  input  logic [32*NUM_MASTERS-1:0]      i_m_wb_adr,
  input  logic [3*NUM_MASTERS-1:0]       i_m_wb_cti,
  output logic [NUM_MASTERS-1:0]         o_m_wb_ack,
  output logic                           o_wb_cyc,
  output logic                           o_wb_stb,
  output logic                           o_wb_wen,
  output logic [3:0]                     o_wb_sel,
  output logic [31:0]                    o_wb_dat,
  output logic [31:0]                    o_wb_adr,
  output logic [2:0]                     o_wb_cti,
  input  logic                           i_wb_ack,
  output logic [$clog2(NUM_MASTERS)-1:0] o_grant,
  output logic                           o_busy,
  output logic                           o_timeout
);
  localparam int GW = $clog2(NUM_MASTERS);
  localparam int WW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  localparam logic [WW-1:0] WMAX = WW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]    state_ff;
  logic [GW-1:0] owner_ff;
  logic [GW-1:0] winner;
  logic [WW-1:0] wdog_ff;
  logic          busy;
  logic          cyc;
  logic [2:0]    cti;
  logic          tmo;
  logic          rel;

`ifdef ZAP_WB_ARB_FIXED_PRIO_EN
  always_comb begin
    winner = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--)
      if (i_m_wb_stb[GW'(i)]) winner = GW'(i);
  end
`else
  logic [GW-1:0] last_ff;
  logic [GW-1:0] j;
  // Scanning downward leaves the nearest requester after last_ff as the final assignment.
  always_comb begin
    winner = '0;
    j = '0;
    for (int i = NUM_MASTERS; i >= 1; i--) begin
      j = GW'((int'(last_ff) + i) % NUM_MASTERS);
      if (i_m_wb_stb[j]) winner = j;
    end
  end
`endif

  assign busy = state_ff == BUSY;
  assign cyc  = i_m_wb_cyc[owner_ff];
  assign cti  = i_m_wb_cti[int'(owner_ff)*3 +: 3];
  assign tmo  = (TIMEOUT != 0) && busy && cyc && !i_wb_ack && wdog_ff == WMAX;
  assign rel  = !cyc || (i_wb_ack && (cti == 3'b000 || cti == 3'b111)) || tmo;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_ff <= IDLE;
      owner_ff <= '0;
`ifndef ZAP_WB_ARB_FIXED_PRIO_EN
      last_ff  <= GW'(NUM_MASTERS - 1);
`endif
      wdog_ff  <= '0;
    end else if (!busy) begin
      if (|i_m_wb_stb) begin
        state_ff <= BUSY;
        owner_ff <= winner;
`ifndef ZAP_WB_ARB_FIXED_PRIO_EN
        last_ff  <= winner;
`endif
        wdog_ff  <= '0;
      end
    end else begin
      if (rel) state_ff <= IDLE;
      wdog_ff <= i_wb_ack ? '0 : (wdog_ff == WMAX ? wdog_ff : wdog_ff + 1'b1);
    end
  end

  assign o_wb_cyc   = busy & cyc;
  assign o_wb_stb   = busy & i_m_wb_stb[owner_ff];
  assign o_wb_wen   = busy & i_m_wb_wen[owner_ff];
  assign o_wb_sel   = busy ? i_m_wb_sel[int'(owner_ff)*4 +: 4] : '0;
  assign o_wb_dat   = busy ? i_m_wb_dat[int'(owner_ff)*32 +: 32] : '0;
  assign o_wb_adr   = busy ? i_m_wb_adr[int'(owner_ff)*32 +: 32] : '0;
  assign o_wb_cti   = busy ? cti : '0;
  assign o_m_wb_ack = busy ? ({{(NUM_MASTERS-1){1'b0}}, i_wb_ack} << owner_ff) : '0;
  assign o_grant    = owner_ff;
  assign o_busy     = busy;
  assign o_timeout  = tmo;
endmodule

// File: tb/tb_zap_wb_arbiter.sv
// tb_zap_wb_arbiter: table-driven cycle vectors plus directed timeout, abort and reset sequences.
module tb_zap_wb_arbiter;
  logic         clk;
  logic         rst;
  logic [3:0]   m_cyc, m_stb, m_wen, m_ack;
  logic [15:0]  m_sel;
  logic [127:0] m_dat, m_adr;
  logic [11:0]  m_cti;
  logic         wb_cyc, wb_stb, wb_wen, wb_ack, busy, tmo;
  logic [3:0]   wb_sel;
  logic [31:0]  wb_dat, wb_adr;
  logic [2:0]   wb_cti;
  logic [1:0]   grant;
  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic       rst;
    logic [3:0] cyc;
    logic [3:0] stb;
    logic [11:0] cti;
    logic       ack;
    logic       busy;
    logic [1:0] grant;
    logic [3:0] mack;
  } vec_t;
  vec_t tbl[$];

  zap_wb_arbiter #(.NUM_MASTERS(4), .TIMEOUT(8)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_m_wb_cyc(m_cyc), .i_m_wb_stb(m_stb), .i_m_wb_wen(m_wen),
    .i_m_wb_sel(m_sel), .i_m_wb_dat(m_dat), .i_m_wb_adr(m_adr), .i_m_wb_cti(m_cti),
    .o_m_wb_ack(m_ack),
    .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_wen(wb_wen), .o_wb_sel(wb_sel),
    .o_wb_dat(wb_dat), .o_wb_adr(wb_adr), .o_wb_cti(wb_cti),
    .i_wb_ack(wb_ack), .o_grant(grant), .o_busy(busy), .o_timeout(tmo)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic vec_t v(logic r, logic [3:0] c, logic [3:0] s, logic [11:0] t, logic a,
                             logic b, logic [1:0] g, logic [3:0] k);
    vec_t x;
    x.rst = r; x.cyc = c; x.stb = s; x.cti = t; x.ack = a; x.busy = b; x.grant = g; x.mack = k;
    return x;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", nm, a, e);
    end
  endtask

  task automatic apply(input logic r, input logic [3:0] c, input logic [3:0] s,
                       input logic [11:0] t, input logic a);
    rst = r; m_cyc = c; m_stb = s; m_cti = t; wb_ack = a;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic b, input logic [1:0] g,
                            input logic [3:0] k, input logic t);
    logic [9:0] eb;
    eb = b ? {m_cyc[g], m_stb[g], g[0], 4'b0001 << g, m_cti[int'(g)*3 +: 3]} : 10'd0;
    cmp({tag, ".busy"}, {31'd0, busy}, {31'd0, b});
    if (b) cmp({tag, ".grant"}, {30'd0, grant}, {30'd0, g});
    cmp({tag, ".mack"}, {28'd0, m_ack}, {28'd0, k});
    cmp({tag, ".tmo"}, {31'd0, tmo}, {31'd0, t});
    cmp({tag, ".bus"}, {22'd0, wb_cyc, wb_stb, wb_wen, wb_sel, wb_cti}, {22'd0, eb});
    cmp({tag, ".adr"}, wb_adr, b ? 32'hA000_0000 + 32'(g) : 32'd0);
    cmp({tag, ".dat"}, wb_dat, b ? 32'h5A00_0000 + (32'(g) << 4) : 32'd0);
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      m_wen[k] = k[0];
      m_sel[k*4 +: 4] = 4'b0001 << k;
      m_adr[k*32 +: 32] = 32'hA000_0000 + k;
      m_dat[k*32 +: 32] = 32'h5A00_0000 + (k << 4);
    end
    apply(1, 0, 0, 0, 0);
    step();
    step();
    // two classic masters, ack one cycle after stb
    tbl.push_back(v(0, 4'h0, 4'h0, 0, 0, 0, 0, 4'h0));
    tbl.push_back(v(0, 4'h5, 4'h5, 0, 0, 0, 0, 4'h0));
    tbl.push_back(v(0, 4'h5, 4'h5, 0, 0, 1, 0, 4'h0));
    tbl.push_back(v(0, 4'h5, 4'h5, 0, 1, 1, 0, 4'h1));
    tbl.push_back(v(0, 4'h4, 4'h4, 0, 0, 0, 0, 4'h0));
    tbl.push_back(v(0, 4'h4, 4'h4, 0, 0, 1, 2, 4'h0));
    tbl.push_back(v(0, 4'h4, 4'h4, 0, 1, 1, 2, 4'h4));
    tbl.push_back(v(0, 4'h0, 4'h0, 0, 0, 0, 0, 4'h0));
    // all four request continuously, slave acks immediately
    tbl.push_back(v(1, 4'h0, 4'h0, 0, 0, 0, 0, 4'h0));
    for (int r = 0; r < 6; r++) begin
      tbl.push_back(v(0, 4'hF, 4'hF, 0, 1, 0, 0, 4'h0));
      tbl.push_back(v(0, 4'hF, 4'hF, 0, 1, 1, 2'(r % 4), 4'b0001 << (r % 4)));
    end
    tbl.push_back(v(0, 4'h0, 4'h0, 0, 0, 0, 0, 4'h0));
    // master 1 four-beat burst against a pending master 3
    tbl.push_back(v(1, 4'h0, 4'h0, 0, 0, 0, 0, 4'h0));
    tbl.push_back(v(0, 4'hA, 4'hA, {3'd0, 3'd0, 3'd2, 3'd0}, 0, 0, 0, 4'h0));
    tbl.push_back(v(0, 4'hA, 4'hA, {3'd0, 3'd0, 3'd2, 3'd0}, 0, 1, 1, 4'h0));
    for (int r = 0; r < 3; r++)
      tbl.push_back(v(0, 4'hA, 4'hA, {3'd0, 3'd0, 3'd2, 3'd0}, 1, 1, 1, 4'h2));
    tbl.push_back(v(0, 4'hA, 4'hA, {3'd0, 3'd0, 3'd7, 3'd0}, 1, 1, 1, 4'h2));
    tbl.push_back(v(0, 4'h8, 4'h8, 0, 0, 0, 0, 4'h0));
    tbl.push_back(v(0, 4'h8, 4'h8, 0, 1, 1, 3, 4'h8));
    tbl.push_back(v(0, 4'h0, 4'h0, 0, 0, 0, 0, 4'h0));
    foreach (tbl[i]) begin
      apply(tbl[i].rst, tbl[i].cyc, tbl[i].stb, tbl[i].cti, tbl[i].ack);
      if (!tbl[i].rst) check_outs($sformatf("vec%0d", i), tbl[i].busy, tbl[i].grant, tbl[i].mack, 0);
      step();
    end
    // watchdog: master 2 never acked, master 3 waiting
    apply(1, 0, 0, 0, 0);
    step();
    apply(0, 4'hC, 4'hC, 0, 0);
    check_outs("wd.idle", 0, 0, 0, 0);
    step();
    for (int i = 0; i < 8; i++) begin
      check_outs($sformatf("wd.beat%0d", i), 1, 2, 0, i == 7);
      step();
    end
    check_outs("wd.gap", 0, 0, 0, 0);
    step();
    check_outs("wd.next", 1, 3, 0, 0);
    apply(0, 0, 0, 0, 0);
    check_outs("wd.abort", 1, 3, 0, 0);
    step();
    // master 0 aborts mid-burst
    apply(0, 4'h1, 4'h1, 12'd2, 0);
    check_outs("ab.idle", 0, 0, 0, 0);
    step();
    check_outs("ab.wait", 1, 0, 0, 0);
    apply(0, 4'h1, 4'h1, 12'd2, 1);
    check_outs("ab.beat", 1, 0, 4'h1, 0);
    step();
    apply(0, 0, 0, 12'd2, 0);
    check_outs("ab.drop", 1, 0, 0, 0);
    step();
    check_outs("ab.after", 0, 0, 0, 0);
    step();
    // reset while master 3 owns the bus
    apply(1, 0, 0, 0, 0);
    step();
    apply(0, 4'h8, 4'h8, 0, 0);
    step();
    check_outs("rs.own3", 1, 3, 0, 0);
    apply(1, 4'hF, 4'hF, 0, 0);
    step();
    apply(0, 4'hF, 4'hF, 0, 0);
    check_outs("rs.post", 0, 0, 0, 0);
    cmp("rs.grant0", {30'd0, grant}, 32'd0);
    step();
    check_outs("rs.first", 1, 0, 0, 0);
    apply(0, 0, 0, 0, 0);
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
